// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared state encodings and sizing helpers for the round-robin distributor.
package arbitro_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

    localparam int MAX_CH = 16;

    function automatic int clog2_ch(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++)
            if ((1 << i) < n) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/arbitro_rr_sel.sv
// arbitro_rr_sel: combinational rotate-priority search from ptr over channels not almost-full.
module arbitro_rr_sel #(
    parameter int NUM_CH  = 4,
    parameter int SKIP_EN = 1,
    parameter int PTR_W   = 2
) (
    input  logic [PTR_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] almost_full,
    output logic [PTR_W-1:0]  sel,
    output logic              ok
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        idx = '0;
        sel = ptr;
        ok  = !almost_full[ptr];
        if (SKIP_EN != 0) begin
            ok = 1'b0;
            // descending scan so the channel closest to ptr is the last one written
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = PTR_W'((int'(ptr) + k) % NUM_CH);
                if (!almost_full[idx]) begin
                    sel = idx;
                    ok  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_n.sv
// arbitro_rr_n: round-robin distributor from one upstream FIFO to NUM_CH downstream FIFOs.
// Define ARB_COUNT_EN to add saturating per-channel push counters on push_count.
module arbitro_rr_n
    import arbitro_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 6,
    parameter int SKIP_EN = 1
`ifdef ARB_COUNT_EN
    ,
    parameter int CNT_W   = 8
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    empty,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [NUM_CH-1:0]       almost_full,
    output logic                    pop,
    output logic [NUM_CH-1:0]       push,
    output logic [DATA_W-1:0]       data_out
`ifdef ARB_COUNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] push_count
`endif
);

    localparam int PTR_W = clog2_ch(NUM_CH);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] sel_q;
    logic             ok;
    logic             pend;
    state_t           st;

    arbitro_rr_sel #(
        .NUM_CH (NUM_CH),
        .SKIP_EN(SKIP_EN),
        .PTR_W  (PTR_W)
    ) u_sel (
        .ptr        (ptr),
        .almost_full(almost_full),
        .sel        (sel),
        .ok         (ok)
    );

    assign pend     = st == ST_XFER;
    assign pop      = !reset && !empty && ok;
    // the word popped last cycle is on data_in now, so push and data go out together
    assign push     = (pend && !reset) ? NUM_CH'(1) << sel_q : '0;
    assign data_out = (pend && !reset) ? data_in : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= ST_IDLE;
            ptr   <= '0;
            sel_q <= '0;
        end else begin
            st <= pop ? ST_XFER : ST_IDLE;
            if (pop) begin
                sel_q <= sel;
                ptr   <= (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
            end
        end
    end

`ifdef ARB_COUNT_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) cnt <= '0;
            else if (push[c] && !(&cnt)) cnt <= cnt + 1'b1;
        end
        assign push_count[c*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule
